// File: rtl/ltm_touch_adc_responder.sv
// ADC-side responder for the LTM touch-panel serial link. It decodes the
// 8-bit control word clocked in on DIN, returns the selected X/Y sample
// MSB-first on DOUT, pulses BUSY for one DCLK and drives PENIRQ_n from
// pen_down when power-down bits allow it. DCLK/CS/DIN are oversampled.
module ltm_touch_adc_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iADC_DCLK,
  input  logic        iADC_CS,
  input  logic        iADC_DIN,
  output logic        oADC_DOUT,
  output logic        oADC_BUSY,
  output logic        oADC_PENIRQ_n,
  input  logic        pen_down,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value
);

  typedef enum logic [1:0] {IDLE, CMD, CONV, DATA} state_t;

  logic [SYNC_STAGES-1:0] dclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] din_sync;
  logic                   dclk_prev;
  logic                   dclk_s;
  logic                   cs_s;
  logic                   din_s;
  logic                   rise;
  logic                   fall;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  cmd_q, cmd_d;      // A2 A1 A0 MODE
  logic        pd1_q, pd1_d;
  logic [1:0]  pd_q, pd_d;
  logic        mode_q, mode_d;
  logic [11:0] shreg_q, shreg_d;
  logic        busy_q, busy_d;
  logic        dout_q, dout_d;
  logic        penirq_q;

  // Left-justified sample for the addressed channel; 8-bit mode keeps the top byte.
  function automatic logic [11:0] select_sample(input logic [2:0]  addr,
                                                input logic        mode,
                                                input logic [11:0] xv,
                                                input logic [11:0] yv);
    logic [11:0] v;
    case (addr)
      3'b101:  v = xv;
      3'b001:  v = yv;
      default: v = 12'h000;
    endcase
    if (mode) v = {v[11:4], 4'b0000};
    return v;
  endfunction

  // Synchronizer chains for the asynchronous link inputs plus DCLK history.
  always_ff @(posedge clock) begin
    if (reset) begin
      dclk_sync <= '0;
      cs_sync   <= '1;
      dclk_prev <= 1'b0;
    end else begin
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], iADC_DCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], iADC_CS};
      dclk_prev <= dclk_sync[SYNC_STAGES-1];
    end
    din_sync <= {din_sync[SYNC_STAGES-2:0], iADC_DIN};
  end

  assign dclk_s = dclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = dclk_s & ~dclk_prev;
  assign fall   = ~dclk_s & dclk_prev;

  // Frame sequencing: command shift-in on rises, busy/data shift-out on falls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    pd1_d   = pd1_q;
    pd_d    = pd_q;
    mode_d  = mode_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    if (cs_s) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      busy_d  = 1'b0;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && din_s) begin
            state_d = CMD;
            cnt_d   = 4'd1;
          end
        end
        CMD: begin
          if (rise) begin
            cnt_d = cnt_q + 4'd1;
            // Bits 1..4 after the start bit are address and mode; bit 5 (SER/DFR) is dropped.
            if (cnt_q <= 4'd4) cmd_d = {cmd_q[2:0], din_s};
            if (cnt_q == 4'd6) pd1_d = din_s;
            if (cnt_q == 4'd7) begin
              shreg_d = select_sample(cmd_q[3:1], cmd_q[0], x_value, y_value);
              mode_d  = cmd_q[0];
              pd_d    = {pd1_q, din_s};
              cnt_d   = 4'd0;
              state_d = CONV;
            end
          end
        end
        CONV: begin
          if (fall) begin
            if (!busy_q) begin
              busy_d = 1'b1;
            end else begin
              busy_d  = 1'b0;
              dout_d  = shreg_q[11];
              shreg_d = {shreg_q[10:0], 1'b0};
              cnt_d   = mode_q ? 4'd7 : 4'd11;
              state_d = DATA;
            end
          end
        end
        DATA: begin
          if (fall) begin
            if (cnt_q != 4'd0) begin
              dout_d  = shreg_q[11];
              shreg_d = {shreg_q[10:0], 1'b0};
              cnt_d   = cnt_q - 4'd1;
            end else begin
              dout_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control state and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      pd_q     <= 2'b00;
      busy_q   <= 1'b0;
      dout_q   <= 1'b0;
      penirq_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pd_q     <= pd_d;
      busy_q   <= busy_d;
      dout_q   <= dout_d;
      penirq_q <= ((pd_q == 2'b00) && ((state_q == IDLE) || (state_q == CMD))) ?
                  ~pen_down : 1'b1;
    end
  end

  // Command fields and sample shift register carry data only.
  always_ff @(posedge clock) begin
    cmd_q   <= cmd_d;
    pd1_q   <= pd1_d;
    mode_q  <= mode_d;
    shreg_q <= shreg_d;
  end

  assign oADC_DOUT     = dout_q;
  assign oADC_BUSY     = busy_q;
  assign oADC_PENIRQ_n = penirq_q;

endmodule

// File: tb/tb_ltm_touch_adc_responder.sv
// Bench for ltm_touch_adc_responder: plays the touch controller, drives
// framed DCLK/DIN/CS traffic and checks DOUT, BUSY and PENIRQ_n per DCLK
// against expectations computed from frame arithmetic.
module tb_ltm_touch_adc_responder;

  localparam int PH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        dclk;
  logic        cs;
  logic        din;
  logic        dout;
  logic        busy;
  logic        penirq_n;
  logic        pen_down;
  logic [11:0] x_value;
  logic [11:0] y_value;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  pd_model;

  ltm_touch_adc_responder #(.SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .iADC_DCLK    (dclk),
    .iADC_CS      (cs),
    .iADC_DIN     (din),
    .oADC_DOUT    (dout),
    .oADC_BUSY    (busy),
    .oADC_PENIRQ_n(penirq_n),
    .pen_down     (pen_down),
    .x_value      (x_value),
    .y_value      (y_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_penirq(input logic [1:0] pd, input logic pen);
    return (pd == 2'b00) ? ~pen : 1'b1;
  endfunction

  // One CS window: z leading zero rises, the command byte, then zeros up to z+24 DCLKs.
  // When chg is nonzero, x/y are re-randomized at the start of that DCLK.
  task automatic run_frame(input logic [7:0] c, input int z, input logic pen, input int chg);
    logic [11:0] xl;
    logic [11:0] yl;
    logic [11:0] v;
    logic [1:0]  pd_old;
    logic [1:0]  pd_new;
    logic        b;
    logic        e;
    int          len;
    int          idx;
    xl       = x_value;
    yl       = y_value;
    pd_old   = pd_model;
    pd_new   = c[1:0];
    len      = c[3] ? 8 : 12;
    v        = (c[6:4] == 3'b101) ? xl : (c[6:4] == 3'b001) ? yl : 12'h000;
    pen_down = pen;
    cs       = 1'b0;
    for (int k = 1; k <= z + 24; k++) begin
      b   = (k > z && k <= z + 8) ? c[z + 8 - k] : 1'b0;
      din = b;
      if (k == chg) begin
        x_value = 12'($urandom);
        y_value = 12'($urandom);
      end
      repeat (5) @(negedge clock);
      chk($sformatf("busy cmd=%h k=%0d", c, k), busy, (k == z + 9));
      if (k <= z + 8)            e = exp_penirq(pd_old, pen);
      else if (k <= z + 9 + len) e = 1'b1;
      else                       e = exp_penirq(pd_new, pen);
      chk($sformatf("penirq cmd=%h k=%0d", c, k), penirq_n, e);
      repeat (PH - 5) @(negedge clock);
      dclk = 1'b1;
      idx  = k - (z + 10);
      e    = (idx >= 0 && idx < len) ? v[11 - idx] : 1'b0;
      chk($sformatf("dout cmd=%h k=%0d", c, k), dout, e);
      repeat (PH) @(negedge clock);
      dclk = 1'b0;
    end
    repeat (PH) @(negedge clock);
    cs       = 1'b1;
    pd_model = pd_new;
    repeat (6) @(negedge clock);
    chk($sformatf("dout after cmd=%h", c), dout, 1'b0);
    chk($sformatf("busy after cmd=%h", c), busy, 1'b0);
  endtask

  // Partial word: only the first nrise bits of c are clocked in before CS rises.
  task automatic abort_frame(input logic [7:0] c, input int nrise);
    cs = 1'b0;
    for (int k = 1; k <= nrise; k++) begin
      din = c[8 - k];
      repeat (5) @(negedge clock);
      chk($sformatf("abort busy k=%0d", k), busy, 1'b0);
      chk($sformatf("abort penirq k=%0d", k), penirq_n, exp_penirq(pd_model, pen_down));
      repeat (PH - 5) @(negedge clock);
      dclk = 1'b1;
      chk($sformatf("abort dout k=%0d", k), dout, 1'b0);
      repeat (PH) @(negedge clock);
      dclk = 1'b0;
    end
    repeat (4) @(negedge clock);
    cs = 1'b1;
    repeat (10) @(negedge clock);
  endtask

  initial begin
    logic [7:0] c;
    int         z;
    reset    = 1'b1;
    dclk     = 1'b0;
    cs       = 1'b1;
    din      = 1'b0;
    pen_down = 1'b1;
    x_value  = 12'h000;
    y_value  = 12'h000;
    pd_model = 2'b00;
    repeat (3) @(negedge clock);
    chk("reset penirq", penirq_n, 1'b1);
    chk("reset dout", dout, 1'b0);
    chk("reset busy", busy, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    chk("penirq after release", penirq_n, 1'b0);
    repeat (4) @(negedge clock);

    x_value = 12'hA5C;
    run_frame(8'hD0, 0, 1'b1, 0);

    y_value = 12'h3F7;
    run_frame(8'h98, 0, 1'b1, 0);
    run_frame(8'h90, 0, 1'b1, 0);

    run_frame(8'hD3, 0, 1'b1, 0);
    run_frame(8'hD0, 0, 1'b1, 0);

    abort_frame(8'hD3, 6);
    run_frame(8'h90, 0, 1'b0, 0);

    x_value = 12'h69B;
    run_frame(8'hD0, 8, 1'b1, 8 + 14);

    run_frame(8'hA4, 0, 1'b1, 0);

    for (int i = 0; i < 14; i++) begin
      x_value = 12'($urandom);
      y_value = 12'($urandom);
      c       = {1'b1, 7'($urandom)};
      if (i % 3 == 0) c[6:4] = 3'b101;
      if (i % 3 == 1) c[6:4] = 3'b001;
      z = $urandom_range(0, 3);
      run_frame(c, z, 1'($urandom), $urandom_range(z + 10, z + 20));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
